serial_sub: RTL and testbench

// - Bit-serial N-bit subtractor: computes diff = a - b one bit per clock, LSB first.
// - Uses a single 1-bit full-subtractor cell and a registered borrow; the subtract-side counterpart of the ripple adder datapath.
// - Sits beside the ALU as a low-area multi-cycle SUB unit with a start/done handshake.
//

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/serial_sub_sub_1b.sv | 13 +
 rtl/serial_sub.sv | 112 +++++++++++
 tb/tb_serial_sub.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtract unit.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow of a - b: operands differ in sign and the result sign
  // disagrees with the minuend.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                        input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_sub_sub_1b.sv
// One-bit full-subtractor cell: d = a - b - bi, bo = borrow out.
module sub_1b (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with a start/ready/done handshake.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_b_q;
  logic [WIDTH-2:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q, a_msb_q, b_msb_q;
  logic             d_bit, bo_bit, accept, last;
  logic [WIDTH-1:0] res_full;

  sub_1b u_cell (
    .a  (sh_a_q[0]),
    .b  (sh_b_q[0]),
    .bi (br_q),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // The result register is one bit short: the final bit goes straight into diff.
  assign res_full = {d_bit, res_q};
  assign last     = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN:     if (last) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: every register here is small, so all of them take the reset, not just control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      sh_a_q   <= a;
      sh_b_q   <= b;
      a_msb_q  <= a[WIDTH-1];
      b_msb_q  <= b[WIDTH-1];
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (state_q == RUN) begin
      sh_a_q <= sh_a_q >> 1;
      sh_b_q <= sh_b_q >> 1;
      res_q  <= res_full[WIDTH-1:1];
      br_q   <= bo_bit;
      cnt_q  <= cnt_q + 1'b1;
      if (last) begin
        diff     <= res_full;
        borrow   <= bo_bit;
        overflow <= sub_overflow(a_msb_q, b_msb_q, d_bit);
        zero     <= ~|res_full;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (WIDTH=8): driver pushes expected results, monitor checks on done.
module tb_serial_sub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, done, borrow, overflow, zero;
  logic [W-1:0] diff;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_count = 0;
  int   pushed = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_count++;
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("diff",     32'(diff),     32'(e.diff));
        check("borrow",   32'(borrow),   32'(e.borrow));
        check("overflow", 32'(overflow), 32'(e.overflow));
        check("zero",     32'(zero),     32'(e.zero));
      end
    end
  end

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input logic ez, input bit expect_res, input bit keep_start);
    int k = 0;
    start = 1'b1;
    a = ai;
    b = bi;
    while (!ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", 32'(ready), 32'd1);
    if (expect_res) begin
      q.push_back('{diff: ed, borrow: eb, overflow: eo, zero: ez});
      pushed++;
    end
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    a = ~ai;
    b = ~bi;
    check("clear_on_accept", 32'({diff, borrow, overflow, zero}), 32'd0);
    check("busy_after_accept", 32'(ready), 32'd0);
  endtask

  // lat counts negedges since the accepting edge; done must appear at the WIDTH+1-th.
  task automatic wait_done(input int lat_start, input logic [W-1:0] ed);
    int lat = lat_start;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(W + 1));
    @(negedge clk);
    check("hold_diff", 32'(diff), 32'(ed));
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input logic ez);
    issue(ai, bi, ed, eb, eo, ez, 1'b1, 1'b0);
    wait_done(1, ed);
  endtask

  initial begin
    int k, dc;
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(ready), 32'd1);
    check("rst_done",   32'(done),  32'd0);
    check("rst_diff",   32'(diff),  32'd0);
    check("rst_flags",  32'({borrow, overflow, zero}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    run_op(8'h77, 8'h77, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // Start pulse during RUN cycle 3 must be ignored.
    dc = done_count;
    issue(8'h3C, 8'h0F, 8'h2D, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    check("ready_in_run", 32'(ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    wait_done(4, 8'h2D);
    repeat (12) @(negedge clk);
    check("single_done", 32'(done_count - dc), 32'd1);
    check("idle_after_ignored", 32'(ready), 32'd1);

    // Back-to-back with start held high: accepts are WIDTH+2 cycles apart.
    issue(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    k = 1;
    while (!ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("b2b_spacing", 32'(k), 32'(W + 2));
    issue(8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(1, 8'hFF);

    // Reset in RUN cycle 4 aborts with no done pulse.
    dc = done_count;
    issue(8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_outs",  32'({done, diff, borrow, overflow, zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", 32'(done_count - dc), 32'd0);
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("done_total", 32'(done_count), 32'(pushed));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
